decode_stage_hz: RTL and testbench
==================================

// Module: decode_stage_hz
// PURPOSE
//   Parametrised ID stage for the 5-stage MIPS pipeline: register file, sign extend, main control,
//   ID/EX pipeline register, plus load-use hazard detection with stall/bubble insertion, branch-flush
//   bubble, valid tracking and a saturating stall-cycle counter. Sits between IF/ID and execute.
// PARAMETERS
//   DATA_W     32  datapath / register width
//   REG_AW     5   register address width
//   NUM_REGS   32  architectural registers (<= 2**REG_AW); R0 hardwired zero
//   CNT_W      16  stall-counter width
// PORTS
//   clk                     in   1         rising-edge clock
//   rst                     in   1         asynchronous, active-low reset
//   wb_reg_write            in   1         WB register write enable
//   wb_write_reg_location   in   REG_AW    WB destination register
//   mem_wb_write_data       in   DATA_W    WB write data
//   if_id_instr             in   32        instruction from IF/ID
//   if_id_npc               in   DATA_W    PC+4 from IF/ID
//   if_id_valid             in   1         IF/ID holds a real instruction
//   ex_flush                in   1         branch taken: squash the instruction in ID
//   pc_write                out  1         0 = hold PC (stall)
//   if_id_write             out  1         0 = hold IF/ID (stall)
//   id_ex_valid             out  1         ID/EX holds a real instruction
//   id_ex_wb                out  2         {RegWrite, MemtoReg}
//   id_ex_mem               out  3         {Branch, MemRead, MemWrite}
//   id_ex_execute           out  4         {RegDst, ALUSrc, ALUOp[1:0]}
//   id_ex_npc / id_ex_readdat1 / id_ex_readdat2 / id_ex_sign_ext   out  DATA_W
//   id_ex_instr_bits_25_21 / _20_16 / _15_11                       out  REG_AW  rs / rt / rd
//   id_ex_funct             out  6         instr[5:0]
//   stall_cycles            out  CNT_W     count of stall cycles, saturating
// BEHAVIOUR
//   Reset (rst=0, async): all ID/EX outputs, id_ex_valid, stall_cycles and every register-file entry
//     = 0. Outputs stay 0 until first clk edge after rst=1.
//   Decode (opcode -> wb/mem/ex): 0x00 R: 10/000/1010; 0x23 lw: 11/010/0100; 0x2B sw: 00/001/0100;
//     0x04 beq: 00/100/0001; 0x08 addi: 10/000/0100; any other opcode: all zero (NOP).
//   Sign extend: imm[15] replicated to DATA_W.
//   Register file: write on rising edge when wb_reg_write and address != 0; address 0 reads 0.
//     Reads combinational with write-through bypass: same-cycle write to the read address returns
//     mem_wb_write_data. Addresses >= NUM_REGS read 0 and ignore writes.
//   Hazard (combinational): hz = id_ex_valid & id_ex_mem[1] & (id_ex_rt != 0) & if_id_valid &
//     (id_ex_rt == instr[25:21] | id_ex_rt == instr[20:16]).
//   stall = hz & ~ex_flush; pc_write = if_id_write = ~stall.
//   ID/EX update every rising edge, priority: ex_flush > stall > normal.
//     ex_flush or stall: bubble -> wb/mem/ex = 0, id_ex_valid = 0; data fields may load but are don't-care.
//     normal: load decoded fields; id_ex_valid = if_id_valid; if if_id_valid=0 control fields = 0.
//   Latency: ID -> ID/EX outputs 1 cycle. Load-use costs exactly 1 stall cycle (bubble clears hz).
//   stall_cycles: +1 on each edge with stall=1; holds at 2**CNT_W-1.
//   Reset mid-stall: pipeline register goes to bubble, stall drops immediately (id_ex_valid=0).
// TESTING
//   1 Reset: rst=0 mid-run -> all id_ex_* = 0, stall_cycles = 0, pc_write=1 after release.
//   2 WB R5<=0x1234 same cycle as ID reads rs=5 -> id_ex_readdat1 = 0x1234 next edge; write R0 -> reads 0.
//   3 lw $t0(8),0($s0) then add $t1,$t0,$t2 -> one cycle pc_write=if_id_write=0, bubble (ctrl=0,
//     valid=0), add enters ID/EX next cycle; stall_cycles = 1.
//   4 lw to R0 followed by use of R0 -> no stall; lw then independent instr -> no stall.
//   5 Load-use with ex_flush=1 same cycle -> stall=0, bubble inserted, stall_cycles unchanged.
//   6 addi imm=0xFFFE -> id_ex_sign_ext=0xFFFFFFFE, ex=0100, wb=10; opcode 0x3F -> all ctrl 0;
//     force 2**CNT_W stalls -> counter saturates at 0xFFFF.

Source files
------------

// File: rtl/decode_stage_hz_if.sv
// Bus between IF/ID, WB and the decode stage: WB write port, IF/ID inputs, ID/EX register outputs.
interface decode_stage_hz_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic                wb_reg_write;
    logic [REG_AW-1:0]   wb_write_reg_location;
    logic [DATA_W-1:0]   mem_wb_write_data;
    logic [31:0]         if_id_instr;
    logic [DATA_W-1:0]   if_id_npc;
    logic                if_id_valid;
    logic                ex_flush;

    logic                pc_write;
    logic                if_id_write;
    logic                id_ex_valid;
    logic [1:0]          id_ex_wb;
    logic [2:0]          id_ex_mem;
    logic [3:0]          id_ex_execute;
    logic [DATA_W-1:0]   id_ex_npc;
    logic [DATA_W-1:0]   id_ex_readdat1;
    logic [DATA_W-1:0]   id_ex_readdat2;
    logic [DATA_W-1:0]   id_ex_sign_ext;
    logic [REG_AW-1:0]   id_ex_instr_bits_25_21;
    logic [REG_AW-1:0]   id_ex_instr_bits_20_16;
    logic [REG_AW-1:0]   id_ex_instr_bits_15_11;
    logic [5:0]          id_ex_funct;
    logic [CNT_W-1:0]    stall_cycles;

    modport master (
        output wb_reg_write, wb_write_reg_location, mem_wb_write_data,
               if_id_instr, if_id_npc, if_id_valid, ex_flush,
        input  pc_write, if_id_write, id_ex_valid, id_ex_wb, id_ex_mem, id_ex_execute,
               id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext,
               id_ex_instr_bits_25_21, id_ex_instr_bits_20_16, id_ex_instr_bits_15_11,
               id_ex_funct, stall_cycles
    );

    modport slave (
        input  wb_reg_write, wb_write_reg_location, mem_wb_write_data,
               if_id_instr, if_id_npc, if_id_valid, ex_flush,
        output pc_write, if_id_write, id_ex_valid, id_ex_wb, id_ex_mem, id_ex_execute,
               id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext,
               id_ex_instr_bits_25_21, id_ex_instr_bits_20_16, id_ex_instr_bits_15_11,
               id_ex_funct, stall_cycles
    );
endinterface

// File: rtl/decode_stage_hz.sv
// MIPS ID stage: register file, decode, sign extend, ID/EX register, load-use stall and flush bubbles.
module decode_stage_hz #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    decode_stage_hz_if.slave bus
);
    localparam int unsigned IMM_W = 16;

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [IMM_W-1:0]  imm;

    assign opcode = bus.if_id_instr[31:26];
    assign rs     = REG_AW'(bus.if_id_instr[25:21]);
    assign rt     = REG_AW'(bus.if_id_instr[20:16]);
    assign rd     = REG_AW'(bus.if_id_instr[15:11]);
    assign imm    = bus.if_id_instr[15:0];

    logic [1:0] wb_c;
    logic [2:0] mem_c;
    logic [3:0] ex_c;

    // Main control: unknown opcodes decode to a NOP
    always_comb begin
        wb_c  = '0;
        mem_c = '0;
        ex_c  = '0;
        case (opcode)
            6'h00: begin wb_c = 2'b10; mem_c = 3'b000; ex_c = 4'b1010; end
            6'h23: begin wb_c = 2'b11; mem_c = 3'b010; ex_c = 4'b0100; end
            6'h2B: begin wb_c = 2'b00; mem_c = 3'b001; ex_c = 4'b0100; end
            6'h04: begin wb_c = 2'b00; mem_c = 3'b100; ex_c = 4'b0001; end
            6'h08: begin wb_c = 2'b10; mem_c = 3'b000; ex_c = 4'b0100; end
            default: ;
        endcase
    end

    logic [DATA_W-1:0] sext_c;
    assign sext_c = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_en;

    assign wr_en = bus.wb_reg_write && (bus.wb_write_reg_location != '0)
                   && (32'(bus.wb_write_reg_location) < NUM_REGS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[bus.wb_write_reg_location] <= bus.mem_wb_write_data;
        end
    end

    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;

    // Reads bypass a same-cycle WB write so ID never sees stale data
    always_comb begin
        rd1_c = '0;
        rd2_c = '0;
        if (rs != '0 && 32'(rs) < NUM_REGS)
            rd1_c = (wr_en && bus.wb_write_reg_location == rs) ? bus.mem_wb_write_data : regs[rs];
        if (rt != '0 && 32'(rt) < NUM_REGS)
            rd2_c = (wr_en && bus.wb_write_reg_location == rt) ? bus.mem_wb_write_data : regs[rt];
    end

    logic              id_ex_valid_q;
    logic [1:0]        id_ex_wb_q;
    logic [2:0]        id_ex_mem_q;
    logic [3:0]        id_ex_ex_q;
    logic [DATA_W-1:0] id_ex_npc_q;
    logic [DATA_W-1:0] id_ex_rd1_q;
    logic [DATA_W-1:0] id_ex_rd2_q;
    logic [DATA_W-1:0] id_ex_sext_q;
    logic [REG_AW-1:0] id_ex_rs_q;
    logic [REG_AW-1:0] id_ex_rt_q;
    logic [REG_AW-1:0] id_ex_rd_q;
    logic [5:0]        id_ex_funct_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic hz_c;
    logic stall_c;

    // Load in EX whose destination is a source of the instruction in ID
    assign hz_c = id_ex_valid_q && id_ex_mem_q[1] && (id_ex_rt_q != '0) && bus.if_id_valid
                  && ((id_ex_rt_q == rs) || (id_ex_rt_q == rt));
    assign stall_c = hz_c && !bus.ex_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_valid_q <= 1'b0;
            id_ex_wb_q    <= '0;
            id_ex_mem_q   <= '0;
            id_ex_ex_q    <= '0;
            id_ex_npc_q   <= '0;
            id_ex_rd1_q   <= '0;
            id_ex_rd2_q   <= '0;
            id_ex_sext_q  <= '0;
            id_ex_rs_q    <= '0;
            id_ex_rt_q    <= '0;
            id_ex_rd_q    <= '0;
            id_ex_funct_q <= '0;
        end else begin
            id_ex_npc_q   <= bus.if_id_npc;
            id_ex_rd1_q   <= rd1_c;
            id_ex_rd2_q   <= rd2_c;
            id_ex_sext_q  <= sext_c;
            id_ex_rs_q    <= rs;
            id_ex_rt_q    <= rt;
            id_ex_rd_q    <= rd;
            id_ex_funct_q <= bus.if_id_instr[5:0];
            if (bus.ex_flush || stall_c) begin
                id_ex_valid_q <= 1'b0;
                id_ex_wb_q    <= '0;
                id_ex_mem_q   <= '0;
                id_ex_ex_q    <= '0;
            end else begin
                id_ex_valid_q <= bus.if_id_valid;
                id_ex_wb_q    <= bus.if_id_valid ? wb_c  : '0;
                id_ex_mem_q   <= bus.if_id_valid ? mem_c : '0;
                id_ex_ex_q    <= bus.if_id_valid ? ex_c  : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt_q <= '0;
        else if (stall_c && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    assign bus.pc_write               = !stall_c;
    assign bus.if_id_write            = !stall_c;
    assign bus.id_ex_valid            = id_ex_valid_q;
    assign bus.id_ex_wb               = id_ex_wb_q;
    assign bus.id_ex_mem              = id_ex_mem_q;
    assign bus.id_ex_execute          = id_ex_ex_q;
    assign bus.id_ex_npc              = id_ex_npc_q;
    assign bus.id_ex_readdat1         = id_ex_rd1_q;
    assign bus.id_ex_readdat2         = id_ex_rd2_q;
    assign bus.id_ex_sign_ext         = id_ex_sext_q;
    assign bus.id_ex_instr_bits_25_21 = id_ex_rs_q;
    assign bus.id_ex_instr_bits_20_16 = id_ex_rt_q;
    assign bus.id_ex_instr_bits_15_11 = id_ex_rd_q;
    assign bus.id_ex_funct            = id_ex_funct_q;
    assign bus.stall_cycles           = stall_cnt_q;
endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz with an ID/EX scoreboard and a narrow-counter instance for saturation.
module tb_decode_stage_hz;
    logic clk;
    logic rst;

    decode_stage_hz_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) ifm ();
    decode_stage_hz_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  ifs ();

    decode_stage_hz #(.DATA_W(32), .REG_AW(5), .NUM_REGS(32), .CNT_W(16)) u_dut (
        .clk (clk), .rst (rst), .bus (ifm.slave));
    decode_stage_hz #(.DATA_W(32), .REG_AW(5), .NUM_REGS(32), .CNT_W(4)) u_dut_sat (
        .clk (clk), .rst (rst), .bus (ifs.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        valid;
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [3:0]  ex;
        logic [31:0] npc, rd1, rd2, sext;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
        logic        data_chk;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_id;
    logic [31:0] m_regs [32];
    logic [31:0] m_npc;
    int          m_cnt;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] dec(input logic [5:0] op);
        case (op)
            6'h00:   return {2'b10, 3'b000, 4'b1010};
            6'h23:   return {2'b11, 3'b010, 4'b0100};
            6'h2B:   return {2'b00, 3'b001, 4'b0100};
            6'h04:   return {2'b00, 3'b100, 4'b0001};
            6'h08:   return {2'b10, 3'b000, 4'b0100};
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                            input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_id = '{valid: 1'b0, wb: 2'b0, mem: 3'b0, ex: 4'b0, npc: 32'd0, rd1: 32'd0, rd2: 32'd0,
                 sext: 32'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0, funct: 6'd0, data_chk: 1'b0};
        m_cnt = 0;
        sb.delete();
    endtask

    task automatic drive(input logic [31:0] instr, input logic valid, input logic flush,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        ifm.if_id_instr = instr;  ifs.if_id_instr = instr;
        ifm.if_id_npc   = m_npc;  ifs.if_id_npc   = m_npc;
        ifm.if_id_valid = valid;  ifs.if_id_valid = valid;
        ifm.ex_flush    = flush;  ifs.ex_flush    = flush;
        ifm.wb_reg_write = we;    ifs.wb_reg_write = we;
        ifm.wb_write_reg_location = wa; ifs.wb_write_reg_location = wa;
        ifm.mem_wb_write_data = wd;     ifs.mem_wb_write_data = wd;
    endtask

    // One ID cycle: predict stall and the ID/EX contents, then compare after the edge
    task automatic cycle(input logic [31:0] instr, input logic valid, input logic flush,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        logic hz, stall;
        logic [8:0] c;
        drive(instr, valid, flush, we, wa, wd);
        #1;
        hz = m_id.valid && m_id.mem[1] && (m_id.rt != 5'd0) && valid
             && (m_id.rt == instr[25:21] || m_id.rt == instr[20:16]);
        stall = hz && !flush;
        chk("pc_write", 32'(ifm.pc_write), 32'(!stall));
        chk("if_id_write", 32'(ifm.if_id_write), 32'(!stall));
        c = dec(instr[31:26]);
        e.npc   = m_npc;
        e.rd1   = rf_read(instr[25:21], we, wa, wd);
        e.rd2   = rf_read(instr[20:16], we, wa, wd);
        e.sext  = {{16{instr[15]}}, instr[15:0]};
        e.rs    = instr[25:21];
        e.rt    = instr[20:16];
        e.rd    = instr[15:11];
        e.funct = instr[5:0];
        if (flush || stall) begin
            e.valid = 1'b0; e.wb = 2'b0; e.mem = 3'b0; e.ex = 4'b0; e.data_chk = 1'b0;
        end else begin
            e.valid = valid;
            e.wb  = valid ? c[8:7] : 2'b0;
            e.mem = valid ? c[6:4] : 3'b0;
            e.ex  = valid ? c[3:0] : 4'b0;
            e.data_chk = 1'b1;
        end
        sb.push_back(e);
        m_id = e;
        if (stall) m_cnt++;
        if (we && wa != 5'd0) m_regs[wa] = wd;
        @(posedge clk);
        #1;
        if (!stall) m_npc = m_npc + 32'd4;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("id_ex_valid", 32'(ifm.id_ex_valid), 32'(e.valid));
            chk("id_ex_wb", 32'(ifm.id_ex_wb), 32'(e.wb));
            chk("id_ex_mem", 32'(ifm.id_ex_mem), 32'(e.mem));
            chk("id_ex_execute", 32'(ifm.id_ex_execute), 32'(e.ex));
            if (e.data_chk) begin
                chk("id_ex_npc", ifm.id_ex_npc, e.npc);
                chk("id_ex_readdat1", ifm.id_ex_readdat1, e.rd1);
                chk("id_ex_readdat2", ifm.id_ex_readdat2, e.rd2);
                chk("id_ex_sign_ext", ifm.id_ex_sign_ext, e.sext);
                chk("id_ex_rs", 32'(ifm.id_ex_instr_bits_25_21), 32'(e.rs));
                chk("id_ex_rt", 32'(ifm.id_ex_instr_bits_20_16), 32'(e.rt));
                chk("id_ex_rd", 32'(ifm.id_ex_instr_bits_15_11), 32'(e.rd));
                chk("id_ex_funct", 32'(ifm.id_ex_funct), 32'(e.funct));
            end
        end
        chk("stall_cycles", 32'(ifm.stall_cycles), 32'(m_cnt));
        chk("stall_cycles_sat4", 32'(ifs.stall_cycles), (m_cnt > 15) ? 32'd15 : 32'(m_cnt));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(ifm.id_ex_valid), 32'd0);
        chk({tag, "_wb"}, 32'(ifm.id_ex_wb), 32'd0);
        chk({tag, "_mem"}, 32'(ifm.id_ex_mem), 32'd0);
        chk({tag, "_ex"}, 32'(ifm.id_ex_execute), 32'd0);
        chk({tag, "_npc"}, ifm.id_ex_npc, 32'd0);
        chk({tag, "_rd1"}, ifm.id_ex_readdat1, 32'd0);
        chk({tag, "_rd2"}, ifm.id_ex_readdat2, 32'd0);
        chk({tag, "_sext"}, ifm.id_ex_sign_ext, 32'd0);
        chk({tag, "_rs"}, 32'(ifm.id_ex_instr_bits_25_21), 32'd0);
        chk({tag, "_rt"}, 32'(ifm.id_ex_instr_bits_20_16), 32'd0);
        chk({tag, "_rd"}, 32'(ifm.id_ex_instr_bits_15_11), 32'd0);
        chk({tag, "_funct"}, 32'(ifm.id_ex_funct), 32'd0);
        chk({tag, "_cnt"}, 32'(ifm.stall_cycles), 32'd0);
        chk({tag, "_cnt_sat4"}, 32'(ifs.stall_cycles), 32'd0);
        chk({tag, "_pc_write"}, 32'(ifm.pc_write), 32'd1);
    endtask

    task automatic mid_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        check_reset_outputs(tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    localparam logic [31:0] LW8     = 32'h8E08_0000;  // lw  $8, 0($16)
    localparam logic [31:0] LW0     = 32'h8E00_0000;  // lw  $0, 0($16)
    localparam logic [31:0] LW8_SELF = 32'h8D08_0000; // lw  $8, 0($8)

    initial begin
        checks = 0;
        errors = 0;
        m_npc  = 32'h0000_0100;
        model_reset();
        rst = 1'b0;
        drive(32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        @(negedge clk);
        rst = 1'b1;

        // Preload registers through WB with no valid instruction in ID
        cycle(32'd0, 1'b0, 1'b0, 1'b1, 5'd8,  32'h8888_0008);
        cycle(32'd0, 1'b0, 1'b0, 1'b1, 5'd10, 32'hAAAA_000A);
        cycle(32'd0, 1'b0, 1'b0, 1'b1, 5'd11, 32'hBBBB_000B);
        cycle(32'd0, 1'b0, 1'b0, 1'b1, 5'd16, 32'h1600_0010);

        // Write-through bypass, then R0 write ignored
        cycle(mk_r(5'd5, 5'd10, 5'd1), 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
        chk("bypass_rs", ifm.id_ex_readdat1, 32'h0000_1234);
        cycle(mk_r(5'd0, 5'd5, 5'd2), 1'b1, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        chk("r0_bypass_zero", ifm.id_ex_readdat1, 32'd0);
        cycle(mk_r(5'd0, 5'd0, 5'd3), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("r0_stays_zero", ifm.id_ex_readdat1, 32'd0);

        // Load-use: one stall, bubble, then the consumer enters
        cycle(LW8, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(mk_r(5'd8, 5'd10, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lu_bubble_valid", 32'(ifm.id_ex_valid), 32'd0);
        cycle(mk_r(5'd8, 5'd10, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lu_stall_count", 32'(ifm.stall_cycles), 32'd1);

        // No hazard on R0 destination or on independent use
        cycle(LW0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(mk_r(5'd0, 5'd0, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(LW8, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(mk_r(5'd10, 5'd11, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);

        // Flush wins over load-use stall
        cycle(LW8, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(mk_r(5'd10, 5'd8, 5'd9), 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("flush_cnt_unchanged", 32'(ifm.stall_cycles), 32'd1);
        cycle(mk_r(5'd10, 5'd8, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);

        // Decode table corners
        cycle(mk_i(6'h08, 5'd0, 5'd3, 16'hFFFE), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("addi_sext", ifm.id_ex_sign_ext, 32'hFFFF_FFFE);
        chk("addi_ex", 32'(ifm.id_ex_execute), 32'h4);
        chk("addi_wb", 32'(ifm.id_ex_wb), 32'h2);
        cycle(mk_i(6'h3F, 5'd1, 5'd2, 16'h0001), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("opc3f_ctrl", {23'd0, ifm.id_ex_wb, ifm.id_ex_mem, ifm.id_ex_execute}, 32'd0);
        cycle(mk_i(6'h2B, 5'd16, 5'd8, 16'h0004), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(mk_i(6'h04, 5'd8, 5'd10, 16'h8000), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(mk_r(5'd8, 5'd10, 5'd9), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Reset asserted while a stall is active
        cycle(LW8, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(mk_r(5'd8, 5'd10, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("pre_reset_stall", 32'(ifm.pc_write), 32'd0);
        mid_reset("mid_reset");

        // Self-dependent load stalls every other cycle; narrow counter must saturate
        for (int i = 0; i < 40; i++)
            cycle(LW8_SELF, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("sat4_final", 32'(ifs.stall_cycles), 32'd15);
        chk("cnt16_final", 32'(ifm.stall_cycles), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
